// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns spi_slave byte frames into simple register-bus reads and writes.
// Build option: define SPIREG_AUTOINC_EN to step reg_addr through bursts (default holds the command address).
module spi_reg_ctrl #(
  parameter int              SIZE     = 8,
  parameter logic [SIZE-1:0] CMD_RESP = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] spi_data_mosi,
  input  logic            spi_data_valid,
  input  logic            spi_cs_d,
  output logic [SIZE-1:0] spi_data_miso,
  output logic [SIZE-2:0] reg_addr,
  output logic [SIZE-1:0] reg_wdata,
  output logic            reg_wr,
  output logic            reg_rd,
  input  logic [SIZE-1:0] reg_rdata,
  output logic            frame_active,
  output logic            frame_done,
  output logic [SIZE-1:0] frame_bytes
);

  localparam int AW = SIZE - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [SIZE-1:0] byte_cnt_reg;
  logic            capture_reg;
  logic [AW-1:0]   addr_next;
  logic [SIZE-1:0] byte_cnt_next;

`ifdef SPIREG_AUTOINC_EN
  assign addr_next = reg_addr + AW'(1);
`else
  assign addr_next = reg_addr;
`endif

  // Byte count sticks at all-ones instead of wrapping.
  assign byte_cnt_next = (byte_cnt_reg == {SIZE{1'b1}}) ? byte_cnt_reg
                                                        : byte_cnt_reg + SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      byte_cnt_reg  <= '0;
      capture_reg   <= 1'b0;
      spi_data_miso <= CMD_RESP;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      frame_active  <= 1'b0;
      frame_done    <= 1'b0;
      frame_bytes   <= '0;
    end else begin
      reg_wr      <= 1'b0;
      reg_rd      <= 1'b0;
      frame_done  <= 1'b0;
      capture_reg <= reg_rd;

      // Write address moves only after the strobe cycle, so the strobe sees a stable address.
      if (reg_wr) begin
        reg_addr <= addr_next;
      end

      case (state_reg)
        IDLE: begin
          if (!spi_cs_d) begin
            state_reg     <= CMD;
            frame_active  <= 1'b1;
            byte_cnt_reg  <= '0;
            spi_data_miso <= CMD_RESP;
          end
        end

        default: begin
          if (spi_cs_d) begin
            // Close wins over a byte arriving in the same cycle.
            state_reg     <= IDLE;
            frame_active  <= 1'b0;
            spi_data_miso <= CMD_RESP;
            if (byte_cnt_reg != '0) begin
              frame_done  <= 1'b1;
              frame_bytes <= byte_cnt_reg;
            end
          end else begin
            if (capture_reg && state_reg == READ) begin
              spi_data_miso <= reg_rdata;
            end
            if (spi_data_valid) begin
              byte_cnt_reg <= byte_cnt_next;
              case (state_reg)
                CMD: begin
                  reg_addr <= spi_data_mosi[AW-1:0];
                  if (spi_data_mosi[SIZE-1]) begin
                    state_reg <= READ;
                    reg_rd    <= 1'b1;
                  end else begin
                    state_reg <= WRITE;
                  end
                end
                WRITE: begin
                  reg_wdata <= spi_data_mosi;
                  reg_wr    <= 1'b1;
                end
                READ: begin
                  // Dummy byte: prefetch the next register for the following byte slot.
                  reg_addr <= addr_next;
                  reg_rd   <= 1'b1;
                end
                default: begin
                  reg_rd <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized self-checking bench for spi_reg_ctrl against a frame-level reference model.
// Honours SPIREG_AUTOINC_EN to pick the expected address step.
module tb_spi_reg_ctrl;

  localparam logic [7:0] CMD_RESP = 8'h00;
`ifdef SPIREG_AUTOINC_EN
  localparam logic [6:0] INC = 7'd1;
`else
  localparam logic [6:0] INC = 7'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] spi_data_mosi = '0;
  logic       spi_data_valid = 1'b0;
  logic       spi_cs_d = 1'b1;
  logic [7:0] spi_data_miso;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = '0;
  logic       frame_active;
  logic       frame_done;
  logic [7:0] frame_bytes;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  int rd_count = 0;
  int done_count = 0;
  int both_count = 0;
  logic [7:0] last_bytes = '0;

  spi_reg_ctrl #(.SIZE(8), .CMD_RESP(CMD_RESP)) dut (
    .clk(clk), .rst(rst),
    .spi_data_mosi(spi_data_mosi), .spi_data_valid(spi_data_valid), .spi_cs_d(spi_cs_d),
    .spi_data_miso(spi_data_miso), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .frame_active(frame_active), .frame_done(frame_done), .frame_bytes(frame_bytes)
  );

  always #5 clk = ~clk;

  // Register-bus slave: data is addr^0x5A, returned the cycle after the read strobe.
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= {1'b0, reg_addr} ^ 8'h5A;
  end

  always @(negedge clk) begin
    if (reg_wr) wr_count++;
    if (reg_rd) rd_count++;
    if (frame_done) done_count++;
    if (reg_wr && reg_rd) both_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data_mosi  = b;
    spi_data_valid = 1'b1;
    tick();
    spi_data_valid = 1'b0;
  endtask

  task automatic gap();
    tick();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  // mode 0: normal close; mode 1: CS rises together with the last data byte.
  task automatic run_frame(input bit rd, input logic [6:0] a, input int nd, input int mode);
    logic [7:0] b;
    logic [6:0] ea;
    int wr0, rd0, cnt, exp_wr, exp_rd;
    wr0 = wr_count; rd0 = rd_count;
    cnt = 1; exp_wr = 0; exp_rd = rd ? 1 : 0;
    ea = a;
    spi_cs_d = 1'b0;
    tick();
    check("open_active", frame_active, 1);
    send_byte({rd, a});
    check("cmd_addr", reg_addr, a);
    check("cmd_rd", reg_rd, rd);
    check("cmd_wr", reg_wr, 0);
    tick(); tick();
    check("cmd_miso", spi_data_miso, rd ? ({1'b0, a} ^ 8'h5A) : CMD_RESP);
    for (int i = 0; i < nd; i++) begin
      gap();
      b = 8'($urandom);
      if (mode == 1 && i == nd - 1) begin
        spi_cs_d = 1'b1;
        send_byte(b);
        check("sim_wr", reg_wr, 0);
        check("sim_rd", reg_rd, 0);
        check("sim_active", frame_active, 0);
        check("sim_done", frame_done, 1);
        last_bytes = (cnt > 255) ? 8'hFF : 8'(cnt);
        check("sim_bytes", frame_bytes, last_bytes);
        break;
      end
      if (rd) begin
        ea = ea + INC;
        send_byte(b);
        check("rd_strobe", reg_rd, 1);
        check("rd_addr", reg_addr, ea);
        tick(); tick();
        check("rd_miso", spi_data_miso, {1'b0, ea} ^ 8'h5A);
        exp_rd++;
      end else begin
        send_byte(b);
        check("wr_strobe", reg_wr, 1);
        check("wr_addr", reg_addr, ea);
        check("wr_data", reg_wdata, b);
        tick();
        ea = ea + INC;
        check("wr_addr_adv", reg_addr, ea);
        tick();
        check("wr_miso", spi_data_miso, CMD_RESP);
        exp_wr++;
      end
      cnt++;
    end
    if (mode == 0) begin
      gap();
      spi_cs_d = 1'b1;
      tick();
      check("close_active", frame_active, 0);
      check("close_done", frame_done, 1);
      last_bytes = (cnt > 255) ? 8'hFF : 8'(cnt);
      check("close_bytes", frame_bytes, last_bytes);
      check("close_miso", spi_data_miso, CMD_RESP);
    end
    tick();
    check("done_pulse", frame_done, 0);
    tick();
    check("wr_total", wr_count - wr0, exp_wr);
    check("rd_total", rd_count - rd0, exp_rd);
    $display("frame rd=%0d addr=%02h data_bytes=%0d mode=%0d count=%0d", rd, a, nd, mode, cnt);
  endtask

  initial begin
    int d0, r0;
    repeat (3) tick();
    check("rst_miso", spi_data_miso, CMD_RESP);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_strobes", {reg_wr, reg_rd}, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_bytes", frame_bytes, 0);
    rst = 1'b0;
    tick(); tick();

    run_frame(1'b0, 7'h10, 2, 0);   // write burst
    run_frame(1'b1, 7'h05, 2, 0);   // read burst
    run_frame(1'b0, 7'h7F, 2, 0);   // address wrap
    run_frame(1'b0, 7'h20, 0, 0);   // CS abort before data byte
    run_frame(1'b0, 7'h31, 2, 1);   // close with simultaneous byte (write)
    run_frame(1'b1, 7'h44, 2, 1);   // close with simultaneous byte (read)

    // Empty frame: no bytes, no frame_done.
    d0 = done_count;
    spi_cs_d = 1'b0; tick(); tick();
    spi_cs_d = 1'b1; tick();
    check("empty_active", frame_active, 0);
    tick();
    check("empty_done", done_count - d0, 0);
    check("empty_bytes", frame_bytes, last_bytes);
    $display("frame empty");

    // Reset one cycle after a read command.
    spi_cs_d = 1'b0; tick();
    send_byte(8'h80 | 8'h12);
    d0 = done_count;
    rst = 1'b1; spi_cs_d = 1'b1;
    tick();
    r0 = rd_count;
    check("mid_rst_rd", reg_rd, 0);
    check("mid_rst_addr", reg_addr, 0);
    check("mid_rst_active", frame_active, 0);
    check("mid_rst_miso", spi_data_miso, CMD_RESP);
    check("mid_rst_bytes", frame_bytes, 0);
    rst = 1'b0;
    last_bytes = '0;
    repeat (4) tick();
    check("mid_rst_no_rd", rd_count - r0, 0);
    check("mid_rst_no_done", done_count - d0, 0);
    $display("frame reset-abort");
    run_frame(1'b1, 7'h33, 1, 0);

    // Long write frame: byte counter saturation.
    run_frame(1'b0, 7'h01, 258, 0);

    for (int k = 0; k < 24; k++) begin
      int nd, md;
      nd = $urandom_range(0, 5);
      md = (nd > 0 && $urandom_range(0, 4) == 0) ? 1 : 0;
      run_frame(1'($urandom_range(0, 1)), 7'($urandom), nd, md);
    end

    check("never_both", both_count, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Frame controller that sits behind spi_slave and turns SPI byte streams into accesses on a simple register bus.
- The first byte of each CS-low frame is a command: bit7 = R/W (1 = read), bits[6:0] = start address.
- Following bytes are write data, or dummy bytes during which read data is shifted out.
- Handles address sequencing, read prefetch so spi_data_miso is ready before the next byte load, and frame bookkeeping.

Parameters:
SIZE, 8, SPI word width; must match spi_slave SIZE. Address width is SIZE-1.
CMD_RESP, 8'h00, value on spi_data_miso during the command byte and the whole of write frames.

Ports:
clk  input  1  system clock; same clock as spi_slave.
rst  input  1  synchronous reset, active-high.
spi_data_mosi  input  SIZE  received byte from spi_slave.
spi_data_valid  input  1  one-cycle pulse; spi_data_mosi is valid.
spi_cs_d  input  1  synchronized chip select from spi_slave, active-low.
spi_data_miso  output  SIZE  byte to transmit; registered; loaded by spi_slave at the start of each byte.
reg_addr  output  SIZE-1  register bus address.
reg_wdata  output  SIZE  register bus write data.
reg_wr  output  1  one-cycle write strobe.
reg_rd  output  1  one-cycle read strobe.
reg_rdata  input  SIZE  read data; valid the cycle after reg_rd.
frame_active  output  1  high while a frame is open.
frame_done  output  1  one-cycle pulse when a frame closes after at least one byte.
frame_bytes  output  SIZE  byte count of the last closed frame; saturates at all-ones.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state and outputs are updated on posedge clk.
- Reset values:
  - state IDLE.
  - spi_data_miso = CMD_RESP.
  - reg_addr, reg_wdata, reg_wr, reg_rd, frame_active, frame_done = 0.
  - frame_bytes = 0.
  - internal byte counter = 0.
- rst high mid-frame aborts the frame with no strobe and no frame_done.
- States: IDLE, CMD, WRITE, READ.
- IDLE:
  - spi_cs_d low → CMD next cycle, with frame_active=1, byte counter=0, spi_data_miso=CMD_RESP.
  - spi_data_valid is ignored in IDLE.
- CMD, on spi_data_valid at cycle t:
  - reg_addr <= byte[SIZE-2:0]; byte counter increments.
  - bit7=0 → WRITE.
  - bit7=1 → READ. reg_rd=1 at t+1 with the new reg_addr. reg_rdata is captured into spi_data_miso at t+2, visible at t+3.
- WRITE, on spi_data_valid at t:
  - reg_wdata <= byte and reg_wr=1 at t+1, with reg_addr unchanged during the strobe.
  - reg_addr advances at t+2 (see the optional feature).
  - spi_data_miso stays CMD_RESP.
- READ, on spi_data_valid at t:
  - The received byte is discarded.
  - reg_addr advances at t+1 and reg_rd=1 at t+1 at the new address.
  - spi_data_miso is updated at t+3.
- Address arithmetic: SIZE-1 bits, wraps modulo 2^(SIZE-1); 7'h7F → 7'h00 for SIZE=8.
- Frame close: spi_cs_d high in any non-IDLE state → IDLE next cycle.
  - Next cycle: frame_active=0 and spi_data_miso=CMD_RESP.
  - frame_done=1 for one cycle and frame_bytes=counter, only if counter≥1.
- Close takes priority over a simultaneous spi_data_valid; no strobe is issued for that byte.
- A strobe already scheduled (t+1) for a byte accepted before close still completes. For READ, the captured data is then overwritten by CMD_RESP.
- reg_wr and reg_rd are never high in the same cycle.
- The byte counter saturates at 2^SIZE-1.
- Timing constraints, system level:
  - spi_data_valid pulses are ≥4 clk apart.
  - SCK half-period is ≥6 clk, so spi_data_miso (t+3) is stable before spi_slave's next load.
  - Violations are not detected.

Optional Feature:
SPIREG_AUTOINC_EN
- Defined: reg_addr increments by 1, with wrap, after each write byte and before each read prefetch after the first.
- Undefined: reg_addr holds the command address for the whole frame. Repeated write bytes hit the same register; reads re-read the same address with a reg_rd strobe per byte. Timing is unchanged.

Test Plan:
- Write burst, AUTOINC on: CS low, bytes 0x10,0xAA,0xBB, CS high → reg_wr at addr 0x10 data 0xAA, then addr 0x11 data 0xBB; spi_data_miso=0x00 throughout; frame_done pulse, frame_bytes=3.
- Read burst, AUTOINC on, reg model returns addr^0x5A: bytes 0x85,0xFF,0xFF → reg_rd at 0x05,0x06,0x07; spi_data_miso = 0x5F, then 0x5C, then 0x5D, each visible 3 clk after its data_valid; frame_bytes=3.
- Wrap: write cmd 0x7F plus 2 data bytes → writes at 0x7F then 0x00. With AUTOINC off: both at 0x7F.
- CS abort: CS high during second bit of the data byte after command 0x20 → no reg_wr, IDLE next cycle, frame_done=1, frame_bytes=1. CS toggle with no bytes → frame_done stays 0.
- Simultaneous close: spi_cs_d rises in the same cycle as spi_data_valid in WRITE → no reg_wr for that byte; frame_bytes excludes it.
- Reset mid-read: rst asserted one cycle after the command byte in READ → all outputs at reset values next cycle, no reg_rd, no frame_done; the next frame decodes normally.
